// File: rtl/lfsr_encrypt_stage.sv
// lfsr_encrypt_stage: builds a preamble/message/pad frame, XORs it with a 6-bit LFSR, writes it to dat_mem.
// Optional LFSR_ZERO_CHK_EN: rejects a zero seed and flags an out-of-range tap_sel on err.
module lfsr_encrypt_stage #(
    parameter logic [7:0] MSG_BASE  = 8'd0,
    parameter logic [7:0] OUT_BASE  = 8'd64,
    parameter int         FRAME_LEN = 64,
    parameter int         PRE_MIN   = 7,
    parameter int         PRE_MAX   = 12,
    parameter logic [7:0] PRE_CHAR  = 8'h5F,
    parameter logic [7:0] PAD_CHAR  = 8'h20
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       go,
    input  logic [5:0] seed,
    input  logic [2:0] tap_sel,
    input  logic [3:0] pre_len,
    input  logic [5:0] msg_len,
    output logic [7:0] raddr,
    input  logic [7:0] data_in,
    output logic [7:0] waddr,
    output logic [7:0] data_out,
    output logic       wr_en,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam logic [7:0] FL   = 8'(FRAME_LEN);
    localparam logic [3:0] PMIN = 4'(PRE_MIN);
    localparam logic [3:0] PMAX = 4'(PRE_MAX);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic [5:0] lfsr_q, lfsr_d, taps_q, taps_d;
    logic [7:0] pl_q, pl_d, ml_q, ml_d, k_q, k_d, raddr_q, raddr_d;
    logic       busy_q, busy_d, done_q, done_d;
    logic [5:0] tap_go;
    logic [7:0] pl_go, ml_go, room, ptext, k_ahead;
    logic       start, last;

    assign tap_go  = tap_sel == 3'd1 ? 6'h2D :
                     tap_sel == 3'd2 ? 6'h30 :
                     tap_sel == 3'd3 ? 6'h33 :
                     tap_sel == 3'd4 ? 6'h36 :
                     tap_sel == 3'd5 ? 6'h39 : 6'h21;
    assign pl_go   = pre_len < PMIN ? {4'd0, PMIN} : pre_len > PMAX ? {4'd0, PMAX} : {4'd0, pre_len};
    assign room    = FL - pl_go;
    assign ml_go   = {2'b00, msg_len} > room ? room : {2'b00, msg_len};
    assign start   = go && (state_q == IDLE || state_q == DONE);
    assign last    = k_q == FL - 8'd1;
    assign k_ahead = k_q + 8'd2;
    assign ptext   = k_q < pl_q ? PRE_CHAR : k_q < pl_q + ml_q ? data_in : PAD_CHAR;

`ifdef LFSR_ZERO_CHK_EN
    logic err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        taps_d  = taps_q;
        pl_d    = pl_q;
        ml_d    = ml_q;
        k_d     = k_q;
        raddr_d = raddr_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef LFSR_ZERO_CHK_EN
        err_d   = err_q;
`endif
        if (start) begin
            state_d = LOAD;
            lfsr_d  = seed;
            taps_d  = tap_go;
            pl_d    = pl_go;
            ml_d    = ml_go;
            k_d     = 8'd0;
            raddr_d = MSG_BASE;
            busy_d  = 1'b1;
            done_d  = 1'b0;
`ifdef LFSR_ZERO_CHK_EN
            err_d   = seed == 6'd0 || tap_sel > 3'd5;
            if (seed == 6'd0) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
`endif
        end else if (state_q == LOAD) begin
            state_d = RUN;
        end else if (state_q == RUN) begin
            lfsr_d = {lfsr_q[4:0], ^(lfsr_q & taps_q)};
            k_d    = k_q + 8'd1;
            // Read address runs one byte ahead so data_in lands in the cycle that encrypts it.
            if (k_ahead >= pl_q && k_ahead < pl_q + ml_q)
                raddr_d = MSG_BASE + k_ahead - pl_q;
            if (last) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= IDLE;
            lfsr_q  <= 6'd0;
            taps_q  <= 6'd0;
            pl_q    <= 8'd0;
            ml_q    <= 8'd0;
            k_q     <= 8'd0;
            raddr_q <= MSG_BASE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LFSR_ZERO_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            taps_q  <= taps_d;
            pl_q    <= pl_d;
            ml_q    <= ml_d;
            k_q     <= k_d;
            raddr_q <= raddr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef LFSR_ZERO_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign raddr    = raddr_q;
    assign waddr    = OUT_BASE + k_q;
    assign wr_en    = state_q == RUN;
    assign data_out = wr_en ? ptext ^ {2'b00, lfsr_q} : 8'h00;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_lfsr_encrypt_stage.sv
// tb_lfsr_encrypt_stage: directed frame vectors against a dat_mem model plus reset/abort/go-while-busy sequences.
module tb_lfsr_encrypt_stage;
    logic       clk = 0, init_n = 1, go = 0;
    logic [5:0] seed = 0, msg_len = 0;
    logic [2:0] tap_sel = 0;
    logic [3:0] pre_len = 0;
    logic [7:0] raddr, data_in = 0, waddr, data_out;
    logic       wr_en, busy, done, err;

    logic [7:0] mem [256];
    logic [7:0] plain [64];
    logic [7:0] exp_frame [64];
    logic [7:0] exp_plain [64];
    int wr_cnt = 0;
    int checks = 0, errors = 0;

    localparam logic [5:0] TAPS [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};
`ifdef LFSR_ZERO_CHK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    typedef struct {
        logic [5:0] seed;
        logic [2:0] tsel;
        logic [3:0] pre;
        logic [5:0] msg;
        logic [7:0] b0, b1;
        int         pl, idx, mid;
    } vec_t;
    vec_t vecs [8];

    lfsr_encrypt_stage dut (
        .clk(clk), .init_n(init_n), .go(go), .seed(seed), .tap_sel(tap_sel),
        .pre_len(pre_len), .msg_len(msg_len), .raddr(raddr), .data_in(data_in),
        .waddr(waddr), .data_out(data_out), .wr_en(wr_en), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        data_in <= raddr < 8'd64 ? plain[raddr[5:0]] : mem[raddr];
        if (wr_en) begin
            mem[waddr] <= data_out;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model(input logic [5:0] s0, input logic [2:0] ts, input logic [3:0] pre, input logic [5:0] msg);
        int pl, ml;
        logic [5:0] s, t;
        pl = pre < 7 ? 7 : pre > 12 ? 12 : int'(pre);
        ml = int'(msg) > 64 - pl ? 64 - pl : int'(msg);
        t = TAPS[ts > 5 ? 0 : int'(ts)];
        s = s0;
        for (int k = 0; k < 64; k++) begin
            exp_plain[k] = k < pl ? 8'h5F : k < pl + ml ? plain[k - pl] : 8'h20;
            exp_frame[k] = exp_plain[k] ^ {2'b00, s};
            s = {s[4:0], ^(s & t)};
        end
    endtask

    function automatic int find_idx(input logic [5:0] s0);
        for (int i = 0; i < 6; i++) begin
            logic [5:0] s = s0;
            bit ok = 1;
            for (int k = 0; k < 64; k++) begin
                if ((mem[64 + k] ^ {2'b00, s}) != exp_plain[k]) ok = 0;
                s = {s[4:0], ^(s & TAPS[i])};
            end
            if (ok) return i;
        end
        return -1;
    endfunction

    task automatic check_frame(input string tag);
        int bad = 0;
        for (int k = 0; k < 64; k++) if (mem[64 + k] !== exp_frame[k]) bad++;
        chk({tag, "_frame_bytes_wrong"}, bad, 0);
    endtask

    task automatic run(input vec_t v, output int n, output int nw);
        int w0 = wr_cnt;
        @(negedge clk);
        seed = v.seed; tap_sel = v.tsel; pre_len = v.pre; msg_len = v.msg; go = 1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            go = (n == v.mid);
            if (n == v.mid) begin seed = ~v.seed; tap_sel = v.tsel + 3'd1; pre_len = 4'd15; end
        end while (!done && n < 200);
        go = 0;
        nw = wr_cnt - w0;
    endtask

    initial begin
        int n, nw, w0, run_len;
        bit rej;
        vec_t av;
        for (int i = 0; i < 64; i++) plain[i] = 8'h61 + 8'(i % 26);
        plain[0] = "H"; plain[1] = "E"; plain[2] = "L"; plain[3] = "L"; plain[4] = "O";
        vecs[0] = '{6'h01, 3'd0, 4'd7,  6'd5,  8'h5E, 8'h5C, 7,  0, 0};
        vecs[1] = '{6'h3F, 3'd5, 4'd3,  6'd10, 8'h60, 8'h61, 7,  5, 0};
        vecs[2] = '{6'h2A, 3'd1, 4'd15, 6'd63, 8'h75, 8'h4B, 12, 1, 20};
        vecs[3] = '{6'h15, 3'd2, 4'd8,  6'd5,  8'h4A, 8'h74, 8,  2, 0};
        vecs[4] = '{6'h07, 3'd3, 4'd10, 6'd0,  8'h58, 8'h51, 10, 3, 0};
        vecs[5] = '{6'h21, 3'd4, 4'd12, 6'd20, 8'h7E, 8'h5C, 12, 4, 0};
        vecs[6] = '{6'h01, 3'd7, 4'd9,  6'd3,  8'h5E, 8'h5C, 9,  0, 0};
        vecs[7] = '{6'h00, 3'd0, 4'd7,  6'd5,  8'h5F, 8'h5F, 7,  0, 0};

        #1 init_n = 0;
        #1;
        chk("rst_raddr", raddr, 8'h00);
        chk("rst_waddr", waddr, 8'h40);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        #20 init_n = 1;

        for (int i = 0; i < 8; i++) begin
            model(vecs[i].seed, vecs[i].tsel, vecs[i].pre, vecs[i].msg);
            rej = ZCHK && vecs[i].seed == 6'd0;
            run(vecs[i], n, nw);
            chk($sformatf("v%0d_err", i), err, int'(ZCHK && (vecs[i].seed == 6'd0 || vecs[i].tsel > 3'd5)));
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_busy_after", i), busy, 0);
            chk($sformatf("v%0d_done_cycle", i), n, rej ? 1 : 66);
            chk($sformatf("v%0d_writes", i), nw, rej ? 0 : 64);
            if (!rej) begin
                chk($sformatf("v%0d_byte64", i), mem[64], vecs[i].b0);
                chk($sformatf("v%0d_byte65", i), mem[65], vecs[i].b1);
                check_frame($sformatf("v%0d", i));
                run_len = 0;
                while (run_len < 64 && (mem[64 + run_len] ^ exp_frame[run_len] ^ exp_plain[run_len]) == 8'h5F)
                    run_len++;
                chk($sformatf("v%0d_preamble_len", i), run_len, vecs[i].pl);
                chk($sformatf("v%0d_tap_index", i), find_idx(vecs[i].seed), vecs[i].idx);
            end
        end

        // Abort mid-frame at k=30, then a full rewrite with a different key.
        av = '{6'h2A, 3'd1, 4'd8, 6'd5, 8'h00, 8'h00, 8, 1, 0};
        w0 = wr_cnt;
        @(negedge clk);
        seed = av.seed; tap_sel = av.tsel; pre_len = av.pre; msg_len = av.msg; go = 1;
        n = 0;
        while (n < 32) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            go = 0;
        end
        chk("abort_pre_wr_en", wr_en, 1);
        chk("abort_pre_waddr", waddr, 8'd94);
        chk("abort_pre_busy", busy, 1);
        init_n = 0;
        #1;
        chk("abort_wr_en", wr_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_waddr", waddr, 8'h40);
        chk("abort_raddr", raddr, 8'h00);
        chk("abort_data_out", data_out, 8'h00);
        chk("abort_writes", wr_cnt - w0, 30);
        repeat (10) @(posedge clk);
        #1 chk("abort_no_more_writes", wr_cnt - w0, 30);
        @(negedge clk);
        init_n = 1;
        av = '{6'h0B, 3'd3, 4'd9, 6'd5, 8'h00, 8'h00, 9, 3, 0};
        model(av.seed, av.tsel, av.pre, av.msg);
        run(av, n, nw);
        chk("rewrite_done_cycle", n, 66);
        chk("rewrite_writes", nw, 64);
        check_frame("rewrite");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
